// File: rtl/feature_fetch_pkg.sv
// Feature fetch shared types: request length width and FSM states.
package pkg_featureFetch;
  import pkg_featureCache::*;

  localparam int LEN_WIDTH = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_e;

endpackage

// File: rtl/pkg_featureCache.sv
// Feature cache geometry and read-port bundle types.
package pkg_featureCache;

  localparam int ADDR_WIDTH = 6;
  localparam int WORDS      = 1 << ADDR_WIDTH;
  localparam int WORD_SIZE  = 16;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] raddr;
  } struct_featureCache_Read_In;

  typedef struct packed {
    logic [WORD_SIZE-1:0] rdata;
  } struct_featureCache_Read_Out;

endpackage

// File: rtl/feature_fetch_fifo.sv
// Synchronous FIFO buffering fetched words with their last flag.
module fetch_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW:0]  wp_q, wp_d;
  logic [AW:0]  rp_q, rp_d;
  logic         full;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign count = wp_q - rp_q;
  // Zero when empty so the output bus is clean out of reset.
  assign rdata = empty ? '0 : mem_q[rp_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (push && !full) begin
      mem_d[wp_q[AW-1:0]] = wdata;
      wp_d = wp_q + 1'b1;
    end
    if (pop && !empty) begin
      rp_d = rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/feature_fetch.sv
// Streams req_len cache words from req_base through a credit-limited FIFO.
// Optional FEATURE_FETCH_STATS_EN adds a saturating stall_cnt output.
module feature_fetch
  import pkg_featureCache::*;
  import pkg_featureFetch::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ADDR_WIDTH-1:0]       req_base,
  input  logic [LEN_WIDTH-1:0]        req_len,
  output struct_featureCache_Read_In  fcr_in,
  input  struct_featureCache_Read_Out fcr_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_SIZE-1:0]        out_data,
  output logic                        out_last,
  output logic                        busy
`ifdef FEATURE_FETCH_STATS_EN
  ,
  output logic [31:0]                 stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  infl_q, infl_d;
  logic                  infl_last_q, infl_last_d;

  logic                  accept;
  logic                  issue;
  logic                  pop;
  logic                  f_empty;
  logic [CW-1:0]         f_count;
  logic [CW-1:0]         occ;
  logic [WORD_SIZE:0]    f_rdata;

  assign req_ready    = (state_q == IDLE) && !rst;
  assign accept       = req_valid && req_ready;
  assign busy         = (state_q != IDLE);
  assign fcr_in.raddr = addr_q;

  // Credit counts the read in flight so a push can never hit a full FIFO.
  assign occ   = f_count + CW'(infl_q);
  assign issue = (state_q == FETCH) && (occ < CW'(FIFO_DEPTH));

  assign out_valid = !f_empty;
  assign out_data  = f_rdata[WORD_SIZE-1:0];
  assign out_last  = f_rdata[WORD_SIZE];
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    infl_d      = issue;
    infl_last_d = issue && (rem_q == LEN_WIDTH'(1));
    unique case (state_q)
      IDLE: begin
        if (accept && (req_len != '0)) begin
          state_d = FETCH;
          addr_d  = req_base;
          rem_d   = req_len;
        end
      end
      FETCH: begin
        if (issue) begin
          addr_d = (addr_q == ADDR_WIDTH'(WORDS - 1)) ?
                   '0 : addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
    end
  end

  fetch_fifo #(
    .W     (WORD_SIZE + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (infl_q),
    .wdata ({infl_last_q, fcr_out.rdata}),
    .pop   (pop),
    .rdata (f_rdata),
    .empty (f_empty),
    .count (f_count)
  );

`ifdef FEATURE_FETCH_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_feature_fetch.sv
// Bench for feature_fetch: directed scenarios plus random traffic vs a queue model.
module tb_feature_fetch;
  import pkg_featureCache::*;
  import pkg_featureFetch::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [ADDR_WIDTH-1:0] req_base = '0;
  logic [LEN_WIDTH-1:0] req_len = '0;
  struct_featureCache_Read_In fcr_in;
  struct_featureCache_Read_Out fcr_out = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [WORD_SIZE-1:0] out_data;
  logic out_last;
  logic busy;
`ifdef FEATURE_FETCH_STATS_EN
  logic [31:0] stall_cnt;
  int m_stall = 0;
`endif

  feature_fetch #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_base  (req_base),
    .req_len   (req_len),
    .fcr_in    (fcr_in),
    .fcr_out   (fcr_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
`ifdef FEATURE_FETCH_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct packed {
    logic                 last;
    logic [WORD_SIZE-1:0] data;
  } exp_t;

  logic [WORD_SIZE-1:0] mem [WORDS];
  exp_t exp_q [$];
  logic [WORD_SIZE-1:0] log_d [$];
  logic log_l [$];
  int log_c [$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit m_busy = 0;
  bit rand_ready = 0;
  bit prev_stall = 0;
  logic [WORD_SIZE:0] prev_out = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Cache model: data valid one cycle after the address.
  always @(posedge clk) fcr_out.rdata <= mem[fcr_in.raddr];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               n, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic clear_log();
    log_d.delete();
    log_l.delete();
    log_c.delete();
  endtask

  task automatic do_req(input int b, input int l,
                        output int acc_edge, output int waited);
    bit r;
    req_valid = 1'b1;
    req_base  = ADDR_WIDTH'(b);
    req_len   = LEN_WIDTH'(l);
    waited    = 0;
    acc_edge  = -1;
    while (acc_edge < 0 && waited < 300) begin
      r = req_ready;
      step();
      if (r) acc_edge = cyc;
      else waited++;
    end
    req_valid = 1'b0;
    if (acc_edge < 0) begin
      tests++;
      fails++;
      $display("FAIL req_timeout: base %0d len %0d not accepted", b, l);
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < bound) begin
      step();
      n++;
    end
    if (n >= bound) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: busy %0b pending %0d",
               busy, exp_q.size());
    end
  endtask

  // Scoreboard: the observed stream must match the address-order model.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_busy = 0;
      prev_stall = 0;
`ifdef FEATURE_FETCH_STATS_EN
      m_stall = 0;
`endif
    end else begin
      chk("busy", 32'(busy), 32'(m_busy));
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_word", 32'({out_last, out_data}), 32'(prev_out));
      end
`ifdef FEATURE_FETCH_STATS_EN
      chk("stall_cnt", stall_cnt, 32'(m_stall));
      if (out_valid && !out_ready) m_stall++;
`endif
      if (out_valid && out_ready) begin
        log_d.push_back(out_data);
        log_l.push_back(out_last);
        log_c.push_back(cyc);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_word: got %0h expected none", out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word", 32'({out_last, out_data}), 32'({e.last, e.data}));
          if (e.last) m_busy = 0;
        end
      end
      if (req_valid && req_ready && req_len != '0) begin
        for (int i = 0; i < int'(req_len); i++) begin
          exp_t e;
          e.data = mem[(int'(req_base) + i) % WORDS];
          e.last = (i == int'(req_len) - 1);
          exp_q.push_back(e);
        end
        m_busy = 1;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_last, out_data};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a, w, n;
    int e33 [4];
    e33 = '{62, 63, 0, 1};
    for (int i = 0; i < WORDS; i++) mem[i] = WORD_SIZE'(i);

    // Reset values
    repeat (3) step();
    chk("ready_in_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_raddr", 32'(fcr_in.raddr), 32'd0);
    step();

    // base 5 len 4, full throughput
    clear_log();
    out_ready = 1'b1;
    do_req(5, 4, a, w);
    wait_idle(50);
    chk("t32_count", 32'(log_d.size()), 32'd4);
    if (log_d.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t32_data", 32'(log_d[i]), 32'(5 + i));
        chk("t32_last", 32'(log_l[i]), 32'(i == 3));
        chk("t32_cycle", 32'(log_c[i]), 32'(a + 2 + i));
      end
    end

    // address wrap
    clear_log();
    do_req(WORDS - 2, 4, a, w);
    wait_idle(50);
    chk("t33_count", 32'(log_d.size()), 32'd4);
    if (log_d.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t33_data", 32'(log_d[i]), 32'(e33[i]));
      end
    end

    // stalled consumer: reads stop at FIFO_DEPTH
    clear_log();
    out_ready = 1'b0;
    do_req(20, 8, a, w);
    repeat (10) step();
    chk("t34_raddr", 32'(fcr_in.raddr), 32'(20 + DEPTH));
    chk("t34_none_yet", 32'(log_d.size()), 32'd0);
    out_ready = 1'b1;
    wait_idle(60);
    chk("t34_count", 32'(log_d.size()), 32'd8);
    if (log_d.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t34_data", 32'(log_d[i]), 32'(20 + i));
        chk("t34_last", 32'(log_l[i]), 32'(i == 7));
      end
    end

    // zero-length requests
    clear_log();
    do_req(3, 0, a, w);
    chk("t35_busy", 32'(busy), 32'd0);
    chk("t35_ready", 32'(req_ready), 32'd1);
    do_req(9, 0, a, w);
    chk("t35_wait0", 32'(w), 32'd0);
    repeat (3) begin
      step();
      chk("t35_novalid", 32'(out_valid), 32'd0);
    end
    do_req(7, 1, a, w);
    chk("t35_wait1", 32'(w), 32'd0);
    wait_idle(30);
    chk("t35_count", 32'(log_d.size()), 32'd1);
    if (log_d.size() == 1) begin
      chk("t35_data", 32'(log_d[0]), 32'd7);
      chk("t35_last", 32'(log_l[0]), 32'd1);
    end

    // reset mid-request
    do_req(10, 16, a, w);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("t36_valid", 32'(out_valid), 32'd0);
    clear_log();
    repeat (5) step();
    chk("t36_silent", 32'(log_d.size()), 32'd0);
    chk("t36_busy", 32'(busy), 32'd0);
    do_req(0, 2, a, w);
    wait_idle(30);
    chk("t36_count", 32'(log_d.size()), 32'd2);
    if (log_d.size() == 2) begin
      chk("t36_d0", 32'(log_d[0]), 32'd0);
      chk("t36_d1", 32'(log_d[1]), 32'd1);
      chk("t36_l0", 32'(log_l[0]), 32'd0);
      chk("t36_l1", 32'(log_l[1]), 32'd1);
    end

`ifdef FEATURE_FETCH_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    do_req(0, 4, a, w);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("t37_valid", 32'(out_valid), 32'd1);
    repeat (7) step();
    chk("t37_stalls", stall_cnt, 32'd7);
    out_ready = 1'b1;
    wait_idle(30);
`endif

    // random traffic
    for (int i = 0; i < WORDS; i++) mem[i] = WORD_SIZE'($urandom);
    rand_ready = 1;
    repeat (40) begin
      do_req($urandom_range(0, WORDS - 1), $urandom_range(0, 20), a, w);
      repeat ($urandom_range(0, 3)) step();
    end
    wait_idle(2000);
    rand_ready = 0;
    out_ready = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/feature_fetch.md
FEATURE_FETCH -- requirements
Module: feature_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in words (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  fetch request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid&&req_ready.
REQ-006 SHALL have port req_base  input  ADDR_WIDTH  first cache word address.
REQ-007 SHALL have port req_len  input  LEN_WIDTH  word count, 0..WORDS.
REQ-008 SHALL have port fcr_in  output  struct_featureCache_Read_In  read address to feature cache.
REQ-009 SHALL have port fcr_out  input  struct_featureCache_Read_Out  cache read data, valid one cycle after address.
REQ-010 SHALL have port out_valid  output  1  out_data valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts word when out_valid&&out_ready.
REQ-012 SHALL have port out_data  output  WORD_SIZE  fetched feature word.
REQ-013 SHALL have port out_last  output  1  marks final word of request.
REQ-014 SHALL have port busy  output  1  high from request accept until last word consumed.

Function
REQ-015 SHALL implement states IDLE, FETCH, DRAIN; req_ready high only in IDLE.
REQ-016 IDLE -> FETCH on accepted request with req_len>0; base and len latched that cycle.
REQ-017 Accepted request with req_len==0 SHALL produce no output and leave state IDLE; busy stays low.
REQ-018 In FETCH, one read SHALL issue per cycle when FIFO occupancy + in-flight reads < FIFO_DEPTH; otherwise fcr_in.raddr held, no read counted.
REQ-019 Read data SHALL be captured into FIFO exactly one cycle after its address issue, with its last flag.
REQ-020 Address SHALL increment by 1 per issued read and wrap from WORDS-1 to 0.
REQ-021 FETCH -> DRAIN in the cycle the final read issues; DRAIN -> IDLE in the cycle the out_last word is consumed.
REQ-022 Output SHALL be in address order, no drops or duplicates, under any out_ready pattern.
REQ-023 out_valid SHALL equal FIFO non-empty; out_data/out_last SHALL stay stable while out_valid&&!out_ready.
REQ-024 Simultaneous FIFO push and pop when full SHALL be impossible by credit rule; push and pop when non-full/non-empty SHALL both occur.
REQ-025 Peak throughput SHALL be 1 word/cycle with out_ready held high; first word out_valid 2 cycles after request accept.

Reset
REQ-026 On rst: state IDLE, FIFO empty, in-flight cleared, fcr_in.raddr=0, out_valid=0, out_last=0, out_data=0, busy=0, req_ready=0 during rst and 1 the cycle after.
REQ-027 rst mid-request SHALL abort; read data returning the cycle after rst SHALL be discarded.

Configuration
REQ-028 Macro FEATURE_FETCH_STATS_EN defined: SHALL add output stall_cnt (32 bits), incrementing each cycle out_valid&&!out_ready, saturating at all-ones, cleared by rst.
REQ-029 Macro undefined: stall_cnt port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-030 Package pkg_featureFetch SHALL hold LEN_WIDTH (=ADDR_WIDTH+1) and the state enum; ADDR_WIDTH, WORD_SIZE, WORDS come from pkg_featureCache.
REQ-031 Output buffer SHALL be a sub-module fetch_fifo (synchronous FIFO, width WORD_SIZE+1, depth FIFO_DEPTH).

Verification
REQ-032 base=5, len=4, out_ready=1, cache word i = i -> out_data 5,6,7,8 on consecutive cycles, out_last only on 8, first valid 2 cycles after accept.
REQ-033 base=WORDS-2, len=4 -> addresses WORDS-2,WORDS-1,0,1 in order.
REQ-034 len=8, out_ready low 10 cycles then high -> exactly FIFO_DEPTH reads issued while stalled, then 8 words in order, none lost.
REQ-035 len=0 -> no out_valid, busy stays 0, next request accepted the following cycle.
REQ-036 rst asserted 3 cycles into len=16 request -> out_valid 0 next cycle, no further words, new request base=0,len=2 yields words 0,1 only.
REQ-037 FEATURE_FETCH_STATS_EN defined, out_ready low 7 cycles with out_valid high -> stall_cnt=7.
